// File: rtl/cpu_defs.sv
// Shared core definitions for the fetch path.
//   CPU_RESET_PC   : first fetch address after reset release
//   BR_BUS_W       : width of the {br_taken, br_target} redirect bus from ID
//   NOP_INST       : LoongArch NOP (andi r0, r0, 0)
//   CPU_FS_TO_DS_W : IF->ID bus width; grows by one bit (fs_adef) when the
//                    IF_ADEF_EXCP_EN macro is defined
package cpu_defs;

    localparam logic [31:0] CPU_RESET_PC = 32'h1c00_0000;
    localparam int          BR_BUS_W     = 33;
    localparam logic [31:0] NOP_INST     = 32'h0340_0000;

`ifdef IF_ADEF_EXCP_EN
    localparam int CPU_FS_TO_DS_W = 65;
`else
    localparam int CPU_FS_TO_DS_W = 64;
`endif

endpackage

// File: rtl/if_inst_buf.sv
// Instruction hold buffer for the fetch stage.
// The instruction SRAM only guarantees rdata in the cycle after a request.
// When ID stalls, the word is captured here so it can be presented until ID
// accepts it.
// Ports:
//   clk, resetn : clock, synchronous active-low reset
//   hold        : IF holds a valid instruction that ID is not taking
//   clear       : ID accepted the instruction, or a redirect discards it
//   rdata       : instruction SRAM read data
//   buf_valid   : buffer holds the current IF instruction
//   inst        : instruction to present (buffer if valid, else live rdata)
module if_inst_buf
    import cpu_defs::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        hold,
    input  logic        clear,
    input  logic [31:0] rdata,
    output logic        buf_valid,
    output logic [31:0] inst
);

    logic [31:0] inst_buf;
    logic        capture;

    // Only the first stall cycle carries good rdata; later cycles must not
    // overwrite the captured word.
    assign capture = hold & ~buf_valid;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            buf_valid <= 1'b0;
        end else if (clear) begin
            buf_valid <= 1'b0;
        end else if (capture) begin
            buf_valid <= 1'b1;
        end
    end

    // NOTE: the data register carries no reset; buf_valid qualifies it, so
    // resetting it would only add logic.
    always_ff @(posedge clk) begin
        if (capture) begin
            inst_buf <= rdata;
        end
    end

    assign inst = buf_valid ? inst_buf : rdata;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage of the 5-stage LoongArch pipeline.
// Generates the next PC, issues a 1-cycle synchronous read to the
// instruction SRAM, holds the fetched PC/instruction and hands them to ID
// over a valid/allowin handshake. Taken branches from ID redirect fetch;
// a redirect that arrives while IF is stalled is remembered until the next
// fetch can be issued.
// Optional macro IF_ADEF_EXCP_EN: flags misaligned fetch PCs (fs_adef, bus
// MSB) and replaces their instruction with a NOP.
// Ports:
//   clk, resetn     : clock, synchronous active-low reset
//   ds_allowin      : ID can accept an instruction this cycle
//   br_bus          : {br_taken, br_target} from ID (combinational pulse)
//   fs_to_ds_valid  : fs_to_ds_bus carries a valid instruction
//   fs_to_ds_bus    : {[fs_adef,] fs_pc, fs_inst}
//   inst_sram_*     : instruction SRAM request / read data
module if_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] RESET_PC   = CPU_RESET_PC,
    parameter int          FS_TO_DS_W = CPU_FS_TO_DS_W
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  ds_allowin,
    input  logic [BR_BUS_W-1:0]   br_bus,
    output logic                  fs_to_ds_valid,
    output logic [FS_TO_DS_W-1:0] fs_to_ds_bus,
    output logic                  inst_sram_en,
    output logic [3:0]            inst_sram_we,
    output logic [31:0]           inst_sram_addr,
    output logic [31:0]           inst_sram_wdata,
    input  logic [31:0]           inst_sram_rdata
);

    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] fs_pc;
    logic        fs_valid;
    logic        br_pend;
    logic [31:0] pend_target;
    logic [31:0] seq_pc;
    logic [31:0] nextpc;
    logic        to_fs_valid;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic [31:0] fs_inst;
    logic        buf_valid;
    logic        buf_clear;

    assign {br_taken, br_target} = br_bus;

    // ---------------- pre-IF ----------------
    // Wraps silently at the top of the address space.
    assign seq_pc      = fs_pc + 32'd4;
    assign to_fs_valid = resetn;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        nextpc = seq_pc;
        if (br_taken) begin
            nextpc = br_target;
        end else if (br_pend) begin
            nextpc = pend_target;
        end
    end

    // ---------------- handshake ----------------
    assign fs_ready_go    = 1'b1;
    assign fs_allowin     = ~fs_valid | (fs_ready_go & ds_allowin);
    assign fs_to_ds_valid = fs_valid & fs_ready_go;

    assign inst_sram_en    = to_fs_valid & fs_allowin;
    assign inst_sram_we    = 4'b0000;
    assign inst_sram_addr  = nextpc;
    assign inst_sram_wdata = 32'h0000_0000;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            // Seeded so the first sequential fetch lands on RESET_PC.
            fs_pc       <= RESET_PC - 32'd4;
            fs_valid    <= 1'b0;
            br_pend     <= 1'b0;
            pend_target <= 32'h0000_0000;
        end else begin
            if (fs_allowin) begin
                fs_valid <= to_fs_valid;
                if (inst_sram_en) begin
                    fs_pc <= nextpc;
                end
            end else if (br_taken) begin
                // Stalled on a wrong-path instruction: squash it so IF
                // frees up and the pending target is fetched next cycle.
                fs_valid <= 1'b0;
            end

            if (br_taken && !fs_allowin) begin
                br_pend     <= 1'b1;
                pend_target <= br_target;
            end else if (inst_sram_en) begin
                // Any issued fetch has consumed the pending target.
                br_pend <= 1'b0;
            end
        end
    end

    // ---------------- instruction buffer ----------------
    assign buf_clear = (fs_to_ds_valid & ds_allowin) | br_taken;

    if_inst_buf u_inst_buf (
        .clk       (clk),
        .resetn    (resetn),
        .hold      (fs_valid & ~ds_allowin),
        .clear     (buf_clear),
        .rdata     (inst_sram_rdata),
        .buf_valid (buf_valid),
        .inst      (fs_inst)
    );

    // ---------------- IF -> ID bus ----------------
`ifdef IF_ADEF_EXCP_EN
    logic fs_adef;
    assign fs_adef      = fs_valid & (fs_pc[1:0] != 2'b00);
    // ID raises ADEF from the flag; the NOP keeps it from decoding garbage.
    assign fs_to_ds_bus = {fs_adef, fs_pc, fs_adef ? NOP_INST : fs_inst};
`else
    assign fs_to_ds_bus = {fs_pc, fs_inst};
`endif

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;
    import cpu_defs::*;

    localparam logic [31:0] GARBAGE = 32'hdead_beef;

    logic                      clk;
    logic                      resetn;
    logic                      ds_allowin;
    logic [BR_BUS_W-1:0]       br_bus;
    logic                      fs_to_ds_valid;
    logic [CPU_FS_TO_DS_W-1:0] fs_to_ds_bus;
    logic                      inst_sram_en;
    logic [3:0]                inst_sram_we;
    logic [31:0]               inst_sram_addr;
    logic [31:0]               inst_sram_wdata;
    logic [31:0]               inst_sram_rdata;

    int checks   = 0;
    int failures = 0;

    // Scoreboard of PCs expected to be handed to ID, in order.
    logic [31:0] exp_q[$];

    if_stage dut (
        .clk             (clk),
        .resetn          (resetn),
        .ds_allowin      (ds_allowin),
        .br_bus          (br_bus),
        .fs_to_ds_valid  (fs_to_ds_valid),
        .fs_to_ds_bus    (fs_to_ds_bus),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_we    (inst_sram_we),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    // SRAM model: data valid only in the cycle after an accepted request.
    always @(posedge clk) begin
        if (inst_sram_en) inst_sram_rdata <= inst_of(inst_sram_addr);
        else              inst_sram_rdata <= GARBAGE;
    end

    // Scoreboard consumer: every IF->ID transfer must match the next entry.
    always @(negedge clk) begin
        if (resetn === 1'b1 && fs_to_ds_valid === 1'b1 && ds_allowin === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected pc=%h (no transfer expected)", fs_to_ds_bus[63:32]);
            end else begin
                logic [31:0] ep;
                ep = exp_q.pop_front();
                if (fs_to_ds_bus[63:32] !== ep || fs_to_ds_bus[31:0] !== inst_of(ep)) begin
                    failures++;
                    $display("FAIL sb_transfer got pc=%h inst=%h exp pc=%h inst=%h",
                             fs_to_ds_bus[63:32], fs_to_ds_bus[31:0], ep, inst_of(ep));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn     = 1'b0;
        ds_allowin = 1'b1;
        br_bus     = '0;
        repeat (3) begin
            tick();
            checks++;
            if (inst_sram_en !== 1'b0 || fs_to_ds_valid !== 1'b0) begin
                failures++;
                $display("FAIL reset_idle got en=%b valid=%b exp 0 0", inst_sram_en, fs_to_ds_valid);
            end
        end
        resetn = 1'b1;
        #1;
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0000) begin
            failures++;
            $display("FAIL reset_first_fetch got en=%b addr=%h exp 1 1c000000", inst_sram_en, inst_sram_addr);
        end
        checks++;
        if (inst_sram_we !== 4'b0 || inst_sram_wdata !== 32'b0) begin
            failures++;
            $display("FAIL sram_write_tieoff got we=%h wdata=%h exp 0 0", inst_sram_we, inst_sram_wdata);
        end
        exp_q.push_back(32'h1c00_0000);
        tick();
        checks++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[63:32] !== 32'h1c00_0000) begin
            failures++;
            $display("FAIL reset_first_valid got valid=%b pc=%h exp 1 1c000000", fs_to_ds_valid, fs_to_ds_bus[63:32]);
        end
    endtask

    task automatic test_stream();
        exp_q.push_back(32'h1c00_0004);
        exp_q.push_back(32'h1c00_0008);
        for (int i = 0; i < 2; i++) begin
            logic [31:0] ea;
            ea = 32'h1c00_0004 + 32'(4 * i);
            checks++;
            if (inst_sram_addr !== ea || inst_sram_en !== 1'b1) begin
                failures++;
                $display("FAIL stream_addr got en=%b addr=%h exp 1 %h", inst_sram_en, inst_sram_addr, ea);
            end
            tick();
            checks++;
            if (fs_to_ds_bus[63:32] !== ea) begin
                failures++;
                $display("FAIL stream_pc got %h exp %h", fs_to_ds_bus[63:32], ea);
            end
        end
    endtask

    task automatic test_stall();
        ds_allowin = 1'b0;
        #1;
        checks++;
        if (inst_sram_en !== 1'b0) begin
            failures++;
            $display("FAIL stall_en got %b exp 0", inst_sram_en);
        end
        repeat (3) begin
            tick();
            checks++;
            if (inst_sram_en !== 1'b0 || fs_to_ds_valid !== 1'b1 ||
                fs_to_ds_bus[63:32] !== 32'h1c00_0008 ||
                fs_to_ds_bus[31:0] !== inst_of(32'h1c00_0008)) begin
                failures++;
                $display("FAIL stall_hold got en=%b valid=%b pc=%h inst=%h exp 0 1 1c000008 %h",
                         inst_sram_en, fs_to_ds_valid, fs_to_ds_bus[63:32], fs_to_ds_bus[31:0],
                         inst_of(32'h1c00_0008));
            end
        end
        ds_allowin = 1'b1;
        exp_q.push_back(32'h1c00_000c);
        #1;
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_000c) begin
            failures++;
            $display("FAIL stall_resume_addr got en=%b addr=%h exp 1 1c00000c", inst_sram_en, inst_sram_addr);
        end
        tick();
        checks++;
        if (fs_to_ds_bus[63:32] !== 32'h1c00_000c || fs_to_ds_bus[31:0] !== inst_of(32'h1c00_000c)) begin
            failures++;
            $display("FAIL stall_resume_inst got pc=%h inst=%h exp 1c00000c %h",
                     fs_to_ds_bus[63:32], fs_to_ds_bus[31:0], inst_of(32'h1c00_000c));
        end
        exp_q.push_back(32'h1c00_0010);
        tick();
    endtask

    task automatic test_branch();
        br_bus = {1'b1, 32'h1c00_0100};
        #1;
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0100) begin
            failures++;
            $display("FAIL branch_addr got en=%b addr=%h exp 1 1c000100", inst_sram_en, inst_sram_addr);
        end
        exp_q.push_back(32'h1c00_0100);
        tick();
        br_bus = '0;
        checks++;
        if (fs_to_ds_bus[63:32] !== 32'h1c00_0100) begin
            failures++;
            $display("FAIL branch_pc got %h exp 1c000100", fs_to_ds_bus[63:32]);
        end
        tick();
        checks++;
        if (fs_to_ds_bus[63:32] !== 32'h1c00_0104) begin
            failures++;
            $display("FAIL branch_seq got %h exp 1c000104", fs_to_ds_bus[63:32]);
        end
    endtask

    task automatic test_redirect_stall();
        ds_allowin = 1'b0;
        br_bus     = {1'b1, 32'h1c00_0200};
        #1;
        checks++;
        if (inst_sram_en !== 1'b0) begin
            failures++;
            $display("FAIL redir_stall_en got %b exp 0", inst_sram_en);
        end
        tick();
        br_bus = '0;
        #1;
        checks++;
        if (fs_to_ds_valid !== 1'b0) begin
            failures++;
            $display("FAIL redir_squash got valid=%b exp 0", fs_to_ds_valid);
        end
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0200) begin
            failures++;
            $display("FAIL redir_pend_fetch got en=%b addr=%h exp 1 1c000200", inst_sram_en, inst_sram_addr);
        end
        exp_q.push_back(32'h1c00_0200);
        tick();
        checks++;
        if (fs_to_ds_valid !== 1'b1 || fs_to_ds_bus[63:32] !== 32'h1c00_0200 || inst_sram_en !== 1'b0) begin
            failures++;
            $display("FAIL redir_target got valid=%b pc=%h en=%b exp 1 1c000200 0",
                     fs_to_ds_valid, fs_to_ds_bus[63:32], inst_sram_en);
        end
        tick();
        ds_allowin = 1'b1;
        tick();
        ds_allowin = 1'b0;
    endtask

    task automatic test_reset_mid();
        br_bus = {1'b1, 32'h1c00_0300};
        tick();
        br_bus = '0;
        resetn = 1'b0;
        #1;
        checks++;
        if (inst_sram_en !== 1'b0) begin
            failures++;
            $display("FAIL midreset_en got %b exp 0", inst_sram_en);
        end
        tick();
        checks++;
        if (fs_to_ds_valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset_valid got %b exp 0", fs_to_ds_valid);
        end
        resetn     = 1'b1;
        ds_allowin = 1'b1;
        #1;
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0000) begin
            failures++;
            $display("FAIL midreset_fetch got en=%b addr=%h exp 1 1c000000", inst_sram_en, inst_sram_addr);
        end
        exp_q.push_back(32'h1c00_0000);
        tick();
        checks++;
        if (fs_to_ds_bus[63:32] !== 32'h1c00_0000 || fs_to_ds_bus[31:0] !== inst_of(32'h1c00_0000)) begin
            failures++;
            $display("FAIL midreset_inst got pc=%h inst=%h exp 1c000000 %h",
                     fs_to_ds_bus[63:32], fs_to_ds_bus[31:0], inst_of(32'h1c00_0000));
        end
        tick();
        ds_allowin = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain got %0d pending exp 0", exp_q.size());
        end
    endtask

    task automatic test_misaligned();
        br_bus = {1'b1, 32'h1c00_0102};
        tick();
        br_bus = '0;
        #1;
        checks++;
        if (inst_sram_en !== 1'b1 || inst_sram_addr !== 32'h1c00_0102) begin
            failures++;
            $display("FAIL misalign_fetch got en=%b addr=%h exp 1 1c000102", inst_sram_en, inst_sram_addr);
        end
        tick();
`ifdef IF_ADEF_EXCP_EN
        checks++;
        if (fs_to_ds_bus[64] !== 1'b1 || fs_to_ds_bus[63:32] !== 32'h1c00_0102 ||
            fs_to_ds_bus[31:0] !== NOP_INST) begin
            failures++;
            $display("FAIL adef got adef=%b pc=%h inst=%h exp 1 1c000102 %h",
                     fs_to_ds_bus[64], fs_to_ds_bus[63:32], fs_to_ds_bus[31:0], NOP_INST);
        end
`else
        checks++;
        if (fs_to_ds_bus[63:32] !== 32'h1c00_0102 || fs_to_ds_bus[31:0] !== inst_of(32'h1c00_0102)) begin
            failures++;
            $display("FAIL misalign_asis got pc=%h inst=%h exp 1c000102 %h",
                     fs_to_ds_bus[63:32], fs_to_ds_bus[31:0], inst_of(32'h1c00_0102));
        end
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_branch();
        test_redirect_stall();
        test_reset_mid();
        test_misaligned();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipelined LoongArch core.
- Sits directly upstream of the decode stage (ID).
- Generates next PC (pre-IF), drives the instruction SRAM (1-cycle synchronous read), holds fetched instruction + PC, hands them to ID over a valid/allowin handshake.
- Accepts branch/jump redirects from ID.

Parameters:
- RESET_PC, 32'h1c000000, first fetched address after reset release
- FS_TO_DS_W, 64, width of fs_to_ds_bus ({fs_pc, fs_inst}); 65 when optional feature compiled in

Ports:
- clk  input  1  core clock
- resetn  input  1  synchronous active-low reset
- ds_allowin  input  1  ID can accept an instruction this cycle
- br_bus  input  33  {br_taken, br_target[31:0]} from ID, combinational, one-cycle pulse
- fs_to_ds_valid  output  1  fs_to_ds_bus holds a valid instruction
- fs_to_ds_bus  output  FS_TO_DS_W  {fs_pc, fs_inst} (+ fs_adef MSB with feature)
- inst_sram_en  output  1  read request
- inst_sram_we  output  4  always 4'b0
- inst_sram_addr  output  32  fetch address (nextpc)
- inst_sram_wdata  output  32  always 32'b0
- inst_sram_rdata  input  32  read data, valid cycle after accepted request

Behaviour:
- Reset (resetn=0 at posedge):
  - fs_pc <= RESET_PC-4
  - fs_valid <= 0
  - buf_valid <= 0
  - br_pend <= 0
  - fs_to_ds_valid = 0
  - inst_sram_en = 0 while resetn=0
- Pre-IF:
  - seq_pc = fs_pc+4 (mod 2^32; wrap 0xfffffffc -> 0x0, no flag)
  - nextpc = br_taken ? br_target : br_pend ? pend_target : seq_pc
  - to_fs_valid = resetn (registered-reset domain: 1 from first cycle after release)
- Handshake:
  - fs_ready_go = 1
  - fs_allowin = !fs_valid | (fs_ready_go & ds_allowin)
  - fs_to_ds_valid = fs_valid & fs_ready_go
  - inst_sram_en = to_fs_valid & fs_allowin
  - On en: fs_valid <= 1, fs_pc <= nextpc
  - If !fs_allowin: fs_pc/fs_valid hold
  - If fs_allowin & !to_fs_valid: fs_valid <= 0
- Instruction buffer:
  - SRAM rdata is guaranteed only in the cycle after the request.
  - If fs_valid & !ds_allowin & !buf_valid: latch rdata into inst_buf, buf_valid <= 1.
  - fs_inst = buf_valid ? inst_buf : inst_sram_rdata
  - buf_valid <= 0 when ID accepts (fs_to_ds_valid & ds_allowin) or on redirect.
- Redirect:
  - br_taken with fs_allowin=1: fetch br_target same cycle; the instruction currently in IF is wrong-path and is replaced, never presented again.
  - br_taken with fs_allowin=0:
    - br_pend <= 1, pend_target <= br_target
    - fs_valid <= 0 (squash)
    - buf_valid <= 0
    - next accepted fetch uses pend_target, which clears br_pend
  - br_taken while br_pend=1: newer target overwrites pend_target.
- Simultaneous: br_taken has priority over br_pend, which has priority over seq_pc.
- Reset mid-operation:
  - all state cleared next edge
  - pending redirect and buffered instruction discarded
  - first fetch after release at RESET_PC
- Latency: fetch request to fs_to_ds_valid = 1 cycle.

Optional Feature:
- Macro: IF_ADEF_EXCP_EN
- With it:
  - fs_adef = fs_valid & (fs_pc[1:0] != 0)
  - fs_to_ds_bus = {fs_adef, fs_pc, fs_inst}, FS_TO_DS_W=65
  - when adef, fs_inst forced to 32'h03400000 (NOP), so ID raises ADEF without decoding garbage
- Without it:
  - fs_to_ds_bus is 64 bits
  - misaligned targets are fetched as-is, no flag

Decomposition:
- Shared package (cpu_defs):
  - RESET_PC
  - BR_BUS_W=33
  - FS_TO_DS_W
  - NOP encoding
  - IF_ADEF_EXCP_EN-dependent width constant
- One sub-module: if_inst_buf (32-bit hold register + buf_valid with capture/clear logic).
- PC/redirect logic stays in the top.

Test Plan:
- Reset release:
  - resetn low 3 cycles, then high
  - first inst_sram_addr=0x1c000000 with en=1
  - fs_to_ds_valid=1 next cycle with fs_pc=0x1c000000
- Steady stream, ds_allowin=1:
  - fs_pc sequence 0x1c000000, 0x1c000004, 0x1c000008
  - fs_inst equals SRAM word for each
- ID stall 3 cycles at 0x1c000008:
  - SRAM rdata changed to garbage after first cycle
  - fs_inst stays original word
  - inst_sram_en=0 during stall
  - resumes with 0x1c00000c
- br_bus={1,0x1c000100} while fs_pc=0x1c000010, allowin=1:
  - next fs_pc=0x1c000100
  - 0x1c000010+4 never issued to ID
- Redirect during stall:
  - br_taken to 0x1c000200, ds_allowin=0
  - fs_to_ds_valid drops
  - first fetch after stall = 0x1c000200
- (IF_ADEF_EXCP_EN) br_target=0x1c000102:
  - fs_adef=1
  - fs_inst=32'h03400000
